// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O controller: splits CPU accesses between external RAM and a small
// register file (output ports, synchronized input ports, change flags, counter, error flag).
module mmio_ctrl #(
    parameter int unsigned DW   = 16,
    parameter int unsigned AW   = 9,
    parameter int unsigned PW   = 8,
    parameter int unsigned NOUT = 2,
    parameter int unsigned NIN  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          mem_cmd,
    input  logic [AW-1:0]       mem_addr,
    input  logic [DW-1:0]       write_data,
    output logic [DW-1:0]       read_data,
    input  logic [DW-1:0]       ram_dout,
    output logic                ram_we,
    output logic [AW-2:0]       ram_addr,
    output logic [DW-1:0]       ram_din,
    input  logic [NIN*PW-1:0]   in_port,
    output logic [NOUT*PW-1:0]  out_port,
    output logic                bus_err
);

    localparam int OW     = AW - 1;
    localparam int OffIn  = 'h40;
    localparam int OffChg = 'h48;
    localparam int OffCnt = 'h50;
    localparam int OffErr = 'h58;

    localparam logic [1:0] MRead  = 2'b01;
    localparam logic [1:0] MWrite = 2'b10;

    logic              rd, wr, io;
    logic [OW-1:0]     off;
    logic              is_out, is_in, is_chg, is_cnt, is_err, mapped;

    logic [NOUT*PW-1:0] out_q, out_d;
    logic [NIN*PW-1:0]  sync1_q, sync2_q, sync3_q;
    logic [NIN-1:0]     chg_q, chg_d, chg_set;
    logic [DW-1:0]      cnt_q, cnt_d;
    logic               err_q, err_d, err_set;

    assign rd  = (mem_cmd == MRead);
    assign wr  = (mem_cmd == MWrite);
    assign io  = mem_addr[AW-1];
    assign off = mem_addr[OW-1:0];

    assign ram_we   = wr & ~io;
    assign ram_addr = mem_addr[AW-2:0];
    assign ram_din  = write_data;
    assign out_port = out_q;
    assign bus_err  = err_q;

    always_comb begin
        is_out = int'(off) < int'(NOUT);
        is_in  = (int'(off) >= OffIn) && (int'(off) < OffIn + int'(NIN));
        is_chg = int'(off) == OffChg;
        is_cnt = int'(off) == OffCnt;
        is_err = int'(off) == OffErr;
        mapped = is_out | is_in | is_chg | is_cnt | is_err;
    end

    always_comb begin
        read_data = '0;
        if (rd) begin
            if (!io) begin
                read_data = ram_dout;
            end else begin
                for (int i = 0; i < int'(NOUT); i++) begin
                    if (int'(off) == i) read_data = DW'(out_q[i*PW +: PW]);
                end
                for (int i = 0; i < int'(NIN); i++) begin
                    if (int'(off) == OffIn + i) read_data = DW'(sync2_q[i*PW +: PW]);
                end
                if (is_chg) read_data = DW'(chg_q);
                if (is_cnt) read_data = cnt_q;
                if (is_err) read_data = DW'(err_q);
            end
        end
    end

    // A port is flagged when any of its bits moved between the last two synchronized samples.
    always_comb begin
        for (int i = 0; i < int'(NIN); i++) begin
            chg_set[i] = sync2_q[i*PW +: PW] != sync3_q[i*PW +: PW];
        end
    end

    always_comb begin
        out_d = out_q;
        for (int i = 0; i < int'(NOUT); i++) begin
            if (wr && io && int'(off) == i) out_d[i*PW +: PW] = write_data[PW-1:0];
        end

        chg_d = chg_q;
        if (wr && io && is_chg) chg_d = chg_q & ~write_data[NIN-1:0];
        chg_d = chg_d | chg_set;

        cnt_d = (wr && io && is_cnt) ? write_data : cnt_q + DW'(1);

        err_set = io & (((rd | wr) & ~mapped) | (wr & is_in));
        err_d   = err_q;
        if (wr && io && is_err && write_data[0]) err_d = 1'b0;
        if (err_set) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            chg_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            sync1_q <= in_port;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            chg_q   <= chg_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl: stimulus pushes expected values, a negedge monitor checks them.
module tb_mmio_ctrl;

    localparam int DW = 16, AW = 9, PW = 8, NOUT = 2, NIN = 2;

    localparam logic [1:0] CNone = 2'b00, CRd = 2'b01, CWr = 2'b10, CBad = 2'b11;
    localparam int KRd = 0, KOut = 1, KErr = 2, KWe = 3, KRAddr = 4, KRDin = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [1:0]          mem_cmd;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       write_data;
    logic [DW-1:0]       read_data;
    logic [DW-1:0]       ram_dout;
    logic                ram_we;
    logic [AW-2:0]       ram_addr;
    logic [DW-1:0]       ram_din;
    logic [NIN*PW-1:0]   in_port;
    logic [NOUT*PW-1:0]  out_port;
    logic                bus_err;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mmio_ctrl #(.DW(DW), .AW(AW), .PW(PW), .NOUT(NOUT), .NIN(NIN)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .ram_dout   (ram_dout),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .in_port    (in_port),
        .out_port   (out_port),
        .bus_err    (bus_err)
    );

    function automatic logic [31:0] actual(int kind);
        case (kind)
            KRd:     return 32'(read_data);
            KOut:    return 32'(out_port);
            KErr:    return 32'(bus_err);
            KWe:     return 32'(ram_we);
            KRAddr:  return 32'(ram_addr);
            default: return 32'(ram_din);
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0) begin
            e   = q.pop_front();
            act = actual(e.kind);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    task automatic expect_v(input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.kind = kind;
        e.exp  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic drive(input logic [1:0] cmd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_cmd    = cmd;
        mem_addr   = a;
        write_data = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        in_port  = '0;
        ram_dout = '0;
        drive(CRd, 9'h150, 16'h0);
        #1;
        expect_v(KRd, 32'h0, "reset_cnt");
        expect_v(KOut, 32'h0, "reset_out");
        expect_v(KErr, 32'h0, "reset_err");
        step();
        reset = 1'b1;
        expect_v(KRd, 32'h0, "cnt_start");
        step();
        expect_v(KRd, 32'h1, "cnt_first_inc");
        step();

        // Output port registers
        drive(CWr, 9'h100, 16'h00A5);
        expect_v(KWe, 32'h0, "io_wr_no_ram_we");
        expect_v(KRd, 32'h0, "wr_read_zero");
        step();
        drive(CRd, 9'h100, 16'h0);
        expect_v(KRd, 32'h00A5, "out0_read");
        expect_v(KOut, 32'h00A5, "out0_port");
        step();
        drive(CWr, 9'h101, 16'h1234);
        step();
        drive(CRd, 9'h101, 16'h0);
        expect_v(KRd, 32'h0034, "out1_read");
        expect_v(KOut, 32'h34A5, "out1_port");
        step();

        // Counter load and wrap
        drive(CWr, 9'h150, 16'hFFFE);
        step();
        drive(CRd, 9'h150, 16'h0);
        expect_v(KRd, 32'hFFFE, "cnt_loaded");
        step();
        expect_v(KRd, 32'hFFFF, "cnt_max");
        step();
        expect_v(KRd, 32'h0000, "cnt_wrap");
        step();

        // Input synchronizer and change flags
        drive(CRd, 9'h148, 16'h0);
        expect_v(KRd, 32'h0, "chg_idle");
        step();
        in_port = 16'h003C;
        drive(CRd, 9'h140, 16'h0);
        expect_v(KRd, 32'h0, "in0_lat0");
        step();
        expect_v(KRd, 32'h0, "in0_lat1");
        step();
        expect_v(KRd, 32'h003C, "in0_lat2");
        step();
        drive(CRd, 9'h148, 16'h0);
        expect_v(KRd, 32'h0001, "chg0_set");
        step();
        drive(CWr, 9'h148, 16'h0001);
        step();
        drive(CRd, 9'h148, 16'h0);
        expect_v(KRd, 32'h0, "chg0_cleared");
        expect_v(KErr, 32'h0, "chg_wr_no_err");
        step();
        in_port = 16'h013C;
        drive(CRd, 9'h141, 16'h0);
        expect_v(KRd, 32'h0, "in1_lat0");
        step();
        step();
        drive(CWr, 9'h148, 16'h0002);
        step();
        drive(CRd, 9'h148, 16'h0);
        expect_v(KRd, 32'h0002, "chg1_set_wins");
        step();
        drive(CWr, 9'h148, 16'h0002);
        step();
        drive(CRd, 9'h148, 16'h0);
        expect_v(KRd, 32'h0, "chg1_cleared");
        step();
        drive(CRd, 9'h141, 16'h0);
        expect_v(KRd, 32'h0001, "in1_read");
        step();

        // Error flag
        drive(CRd, 9'h17F, 16'h0);
        expect_v(KRd, 32'h0, "unmapped_read_zero");
        expect_v(KErr, 32'h0, "err_not_yet");
        step();
        drive(CRd, 9'h158, 16'h0);
        expect_v(KErr, 32'h1, "err_set_unmapped");
        expect_v(KRd, 32'h1, "err_reg_read");
        step();
        drive(CWr, 9'h140, 16'h0055);
        expect_v(KWe, 32'h0, "ro_wr_no_ram_we");
        step();
        drive(CWr, 9'h158, 16'h0000);
        expect_v(KErr, 32'h1, "err_sticky_ro_wr");
        step();
        drive(CWr, 9'h158, 16'h0001);
        expect_v(KErr, 32'h1, "err_no_clear_bit0_0");
        step();
        drive(CNone, 9'h000, 16'h0);
        expect_v(KErr, 32'h0, "err_cleared");
        step();
        drive(CWr, 9'h140, 16'h00FF);
        step();
        drive(CWr, 9'h158, 16'h0001);
        expect_v(KErr, 32'h1, "err_set_ro_wr");
        step();
        drive(CBad, 9'h17F, 16'h0);
        expect_v(KErr, 32'h0, "err_cleared2");
        expect_v(KRd, 32'h0, "cmd11_read_zero");
        step();
        drive(CBad, 9'h023, 16'h0);
        expect_v(KErr, 32'h0, "cmd11_no_err");
        expect_v(KWe, 32'h0, "cmd11_no_ram_we");
        step();

        // RAM region
        drive(CWr, 9'h023, 16'h1234);
        expect_v(KWe, 32'h1, "ram_we");
        expect_v(KRAddr, 32'h23, "ram_addr");
        expect_v(KRDin, 32'h1234, "ram_din");
        step();
        drive(CRd, 9'h023, 16'h0);
        ram_dout = 16'h1234;
        expect_v(KRd, 32'h1234, "ram_read");
        expect_v(KWe, 32'h0, "ram_rd_no_we");
        expect_v(KOut, 32'h34A5, "ram_wr_no_io_change");
        step();
        drive(CRd, 9'h0FF, 16'h0);
        ram_dout = 16'hBEEF;
        expect_v(KRd, 32'hBEEF, "ram_read_top");
        expect_v(KRAddr, 32'hFF, "ram_addr_top");
        step();

        // Asynchronous reset pulse between edges
        drive(CWr, 9'h101, 16'h00FF);
        step();
        in_port = 16'h0000;
        drive(CRd, 9'h101, 16'h0);
        expect_v(KRd, 32'h00FF, "out1_ff");
        expect_v(KOut, 32'hFFA5, "out_before_rst");
        step();
        drive(CNone, 9'h000, 16'h0);
        repeat (3) step();
        drive(CRd, 9'h150, 16'h0);
        #1;
        reset = 1'b0;
        expect_v(KOut, 32'h0, "rst_pulse_out");
        expect_v(KRd, 32'h0, "rst_pulse_cnt");
        expect_v(KErr, 32'h0, "rst_pulse_err");
        @(negedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        expect_v(KRd, 32'h1, "cnt_resume1");
        step();
        expect_v(KRd, 32'h2, "cnt_resume2");
        step();
        drive(CRd, 9'h148, 16'h0);
        for (int i = 0; i < 3; i++) begin
            expect_v(KRd, 32'h0, "chg_quiet_after_rst");
            step();
        end
        drive(CNone, 9'h000, 16'h0);
        step();

        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_ctrl.md
MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 Parameter DW, 16, data width of CPU bus and RAM.
REQ-002 Parameter AW, 9, CPU address width; RAM region is mem_addr[AW-1]==0, IO region is mem_addr[AW-1]==1.
REQ-003 Parameter PW, 8, width of each output and input port (PW<=DW).
REQ-004 Parameter NOUT, 2, number of output port registers (1..64).
REQ-005 Parameter NIN, 2, number of input ports (1..8).
REQ-006 Port clk  in  1  single clock; all state updates on rising edge.
REQ-007 Port reset  in  1  asynchronous, active-low reset.
REQ-008 Port mem_cmd  in  2  00 MNONE, 01 MREAD, 10 MWRITE; 11 treated as MNONE.
REQ-009 Port mem_addr  in  AW  CPU word address.
REQ-010 Port write_data  in  DW  CPU store data.
REQ-011 Port read_data  out  DW  CPU load data.
REQ-012 Port ram_dout  in  DW  RAM read data.
REQ-013 Port ram_we  out  1  RAM write enable.
REQ-014 Port ram_addr  out  AW-1  RAM address = mem_addr[AW-2:0].
REQ-015 Port ram_din  out  DW  RAM write data = write_data.
REQ-016 Port in_port  in  NIN*PW  asynchronous inputs (switches); port i at bits [i*PW+:PW].
REQ-017 Port out_port  out  NOUT*PW  output register contents (LEDs); port i at bits [i*PW+:PW].
REQ-018 Port bus_err  out  1  sticky error flag.

Function
REQ-019 Strobes: rd = mem_cmd==MREAD, wr = mem_cmd==MWRITE; ram_we = wr & region RAM.
REQ-020 IO offset off = mem_addr[AW-2:0]; map: 0x00..NOUT-1 OUT[i] (RW); 0x40..0x40+NIN-1 IN[i] (RO); 0x48 CHG (RW1C); 0x50 CNT (RW); 0x58 ERR (RW1C); all other IO offsets unmapped.
REQ-021 read_data is combinational, same cycle as rd: RAM region -> ram_dout; mapped IO -> register zero-extended to DW; unmapped IO or no rd -> 0; no tri-state drivers.
REQ-022 OUT[i] loads write_data[PW-1:0] on the clock edge with wr & off==i; out_port reflects OUT directly.
REQ-023 Each in_port bit passes through a 2-flop synchronizer; IN[i] reads stage-2 value; visible latency 2 cycles after the input changes.
REQ-024 A third flop per bit holds the previous stage-2 value; CHG[i] sets when any bit of port i differs between stage 2 and stage 3.
REQ-025 CHG write clears bits where write_data[i]==1; a set event on the same edge wins over the clear.
REQ-026 CNT is DW-bit free-running, +1 per cycle, wraps 2^DW-1 -> 0; a CNT write loads write_data and suppresses that cycle's increment.
REQ-027 ERR bit0 sets on rd or wr to an unmapped IO offset or on a write to a RO offset; ERR write with write_data[0]==1 clears it, set wins on the same edge; bus_err = ERR[0].
REQ-028 IO writes never assert ram_we; RAM accesses never change IO state.
REQ-029 Multi-cycle rd has no side effects; repeated reads return the current value.

Reset
REQ-030 reset low asynchronously forces OUT, CHG, CNT, ERR, and all synchronizer flops to 0; out_port=0, bus_err=0.
REQ-031 CHG does not set on the first edges after reset release unless in_port changes relative to the synchronized value.
REQ-032 reset asserted mid-access aborts it; no register retains a partial update.

Verification
REQ-033 wr addr 0x100 data 0x00A5 -> out_port[7:0]=0xA5 next cycle; rd 0x100 -> read_data=0x00A5; ram_we stays 0.
REQ-034 in_port[7:0]=0x3C held -> rd 0x140 returns 0x003C from the 2nd edge on; CHG[0]=1; wr 0x148 data 0x0001 -> CHG[0]=0.
REQ-035 wr 0x150 data 0xFFFE -> CNT reads 0xFFFF one cycle later, then 0x0000 (wrap).
REQ-036 rd 0x17F (unmapped) -> read_data=0, bus_err=1 next cycle; wr 0x140 -> bus_err stays 1; wr 0x158 data 1 -> bus_err=0.
REQ-037 wr 0x023 data 0x1234 -> ram_we=1, ram_addr=0x23; rd 0x023 with ram_dout=0x1234 -> read_data=0x1234.
REQ-038 Pulse reset low between edges with OUT[1]=0xFF and CNT running -> out_port and CNT read 0 immediately; resumes counting from 0 after release.
